weight_load_ctrl: RTL
=====================

Name: weight_load_ctrl

Overview:
- Sequencer for the weight ROM/RAM memory block: on `start`, streams all DEPTH encrypted words of the selected model ROM, decrypts each, and writes it into the weight RAM.
- Arbitrates the single RAM address port between this load engine and the inference datapath's read requests.
- Drives `active_model`, so it sits between `config_interface` and the memory block.

Parameters:
- N, 8: word width; power of two, ≥ 2.
- DEPTH, 16: words per model; power of two, ≥ 2. AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle load request
- model_sel  in  2  model to load: 01 = A, 10 = B
- key  in  N  decryption key, sampled at start acceptance
- abort  in  1  cancel load in progress
- active_model  out  2  ROM select to memory block
- rom_addr  out  AW  ROM address
- rom_data  in  N  ROM read data, one-cycle registered latency
- ram_addr  out  AW  RAM address, muxed between load writes and host reads
- ram_din  out  N  decrypted write data
- ram_write_en  out  1  RAM write strobe
- ram_dout  in  N  RAM read data, one-cycle latency
- rd_req  in  1  datapath read request
- rd_addr  in  AW  datapath read address
- rd_gnt  out  1  combinational grant
- rd_valid  out  1  rd_data valid
- rd_data  out  N  equals ram_dout
- busy  out  1  load in progress
- done  out  1  one-cycle pulse, load complete
- err  out  1  one-cycle pulse, rejected start or checksum failure
- weights_valid  out  1  RAM holds a complete decrypted model

Behaviour:
- Reset (rst = 0, async) clears all state and outputs:
  - state = IDLE; active_model = 00.
  - All addresses and counters = 0.
  - ram_write_en, rd_valid, busy, done, err, weights_valid = 0.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - start with model_sel ∈ {01, 10}: latch model_sel into active_model and key into key_r; clear weights_valid; issue rom_addr = 0; go to STREAM.
  - start with model_sel ∈ {00, 11}: err pulse next cycle; stay IDLE; active_model and weights_valid unchanged.
- STREAM:
  - Increment rom_addr each cycle.
  - Write pipeline: the word addressed in cycle t is written in cycle t+1 with ram_addr = that address and ram_write_en = 1.
  - After issuing DEPTH-1, go to DRAIN.
- DRAIN: write the final word, then go to DONE.
- DONE: done = 1 and weights_valid = 1 for this cycle, then IDLE.
- Latency: start accepted in cycle 0 → writes in cycles 1..DEPTH → done in cycle DEPTH+1.
- Decrypt: ram_din = rom_data XOR rotl(key_r, addr mod N), where addr is the write address.
- Address counters wrap at DEPTH-1 using natural AW-bit wrap; no out-of-range access.
- Arbitration:
  - rd_gnt = rd_req & (state == IDLE) & !start.
  - start wins over a simultaneous read.
  - When granted, ram_addr = rd_addr; rd_valid = 1 the next cycle; rd_data = ram_dout.
  - Reads are allowed even when weights_valid = 0; the data is then stale.
- `start` while busy: ignored, no err.
- `abort` in STREAM or DRAIN: ram_write_en forced 0 in that same cycle; next state IDLE; weights_valid stays 0; no done. `abort` in IDLE: no effect.
- `key` and `model_sel` changes during a load have no effect.

Optional Feature:
- Macro: WEIGHT_LOAD_CTRL_CHECKSUM_EN.
- When defined:
  - Adds input expected_sum[N-1:0], sampled at start acceptance.
  - Adds output checksum[N-1:0]: modulo-2^N sum of all written ram_din words, cleared at start acceptance.
  - In DONE, if checksum ≠ expected_sum: err = 1 and done = 1, but weights_valid stays 0.
- When undefined: no extra ports; DONE always sets weights_valid.

Decomposition:
- Package weight_load_pkg contains:
  - MODEL_NONE = 2'b00, MODEL_A = 2'b01, MODEL_B = 2'b10.
  - State encoding typedef (IDLE/STREAM/DRAIN/DONE).
- One sub-module, weight_decrypt: combinational rotate-and-XOR; inputs key, addr, data; output plain data.

Test Plan:
- Model A load, N=8, DEPTH=16, key = 8'h5A, ROM A = 00..0F: 16 writes in cycles 1..16; addr 1 data = 8'h01 ^ 8'hB4 = 8'hB5; done in cycle 17; weights_valid = 1.
- start with model_sel = 2'b11 → err pulse one cycle later; no rom_addr activity; active_model remains 00.
- rd_req on addr 3 in IDLE after a load → rd_gnt = 1 the same cycle; rd_valid = 1 the next cycle with the decrypted word; rd_req during busy → rd_gnt = 0.
- abort in cycle 6 of a load → ram_write_en = 0 from cycle 6; state IDLE in cycle 7; no done; weights_valid = 0.
- rst asserted mid-STREAM → all outputs 0 immediately (async); after release, a new start loads model B correctly.
- With WEIGHT_LOAD_CTRL_CHECKSUM_EN: expected_sum wrong by 1 → err = 1 and done = 1, weights_valid = 0; correct expected_sum → weights_valid = 1.

Source files
------------

// File: rtl/weight_load_pkg.sv
// Shared model-select codes, load sequencer state type and start validation
// for the weight ROM/RAM load controller.
package weight_load_pkg;

   localparam logic [1:0] MODEL_NONE = 2'b00;
   localparam logic [1:0] MODEL_A    = 2'b01;
   localparam logic [1:0] MODEL_B    = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } load_state_e;

   function automatic logic model_sel_ok(input logic [1:0] sel);
      return (sel == MODEL_A) || (sel == MODEL_B);
   endfunction

endpackage

// File: rtl/weight_decrypt.sv
// Combinational weight decryption: plain = data XOR rotl(key, addr mod N).
module weight_decrypt #(
   parameter int N  = 8,
   parameter int AW = 4
) (
   input  logic [N-1:0]  key,
   input  logic [AW-1:0] addr,
   input  logic [N-1:0]  data,
   output logic [N-1:0]  plain
);

   logic [31:0]  amt;
   logic [N-1:0] key_rot;

   // amt < N, so the right shift by N-amt is at most N and yields 0 when amt = 0
   always_comb begin
      amt     = 32'(addr) % 32'(N);
      key_rot = (key << amt) | (key >> (32'(N) - amt));
      plain   = data ^ key_rot;
   end

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight load sequencer: streams a model ROM through decryption into the weight
// RAM and arbitrates the RAM port with datapath reads. Optional checksum
// verification is enabled with WEIGHT_LOAD_CTRL_CHECKSUM_EN.
module weight_load_ctrl
   import weight_load_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    model_sel,
   input  logic [N-1:0]  key,
   input  logic          abort,
   output logic [1:0]    active_model,
   output logic [AW-1:0] rom_addr,
   input  logic [N-1:0]  rom_data,
   output logic [AW-1:0] ram_addr,
   output logic [N-1:0]  ram_din,
   output logic          ram_write_en,
   input  logic [N-1:0]  ram_dout,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_gnt,
   output logic          rd_valid,
   output logic [N-1:0]  rd_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          weights_valid
`ifdef WEIGHT_LOAD_CTRL_CHECKSUM_EN
   ,
   input  logic [N-1:0]  expected_sum,
   output logic [N-1:0]  checksum
`endif
);

   load_state_e   state_q, state_d;
   logic [AW-1:0] rom_addr_q;
   logic [AW-1:0] wr_addr_q;
   logic          wr_pend_q;
   logic [1:0]    model_q;
   logic [N-1:0]  key_q;
   logic          err_q;
   logic          wv_q;
   logic          rd_valid_q;

   logic          in_idle;
   logic          start_ok;
   logic          start_bad;
   logic          last_issue;
   logic          issue;
   logic          aborting;
   logic          sum_ok;

   assign in_idle    = (state_q == IDLE);
   assign start_ok   = start && in_idle && model_sel_ok(model_sel);
   assign start_bad  = start && in_idle && !model_sel_ok(model_sel);
   assign last_issue = (rom_addr_q == AW'(DEPTH - 1));
   assign aborting   = abort && ((state_q == STREAM) || (state_q == DRAIN));
   // Address 0 is issued in the accepting IDLE cycle, the rest during STREAM
   assign issue      = start_ok || ((state_q == STREAM) && !abort);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_ok) state_d = STREAM;
         STREAM: begin
            if (abort)           state_d = IDLE;
            else if (last_issue) state_d = DRAIN;
         end
         DRAIN:   state_d = abort ? IDLE : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr_q <= '0;
         wr_addr_q  <= '0;
         wr_pend_q  <= 1'b0;
         model_q    <= MODEL_NONE;
         key_q      <= '0;
         err_q      <= 1'b0;
         wv_q       <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         err_q      <= start_bad;
         rd_valid_q <= rd_gnt;
         if (start_ok) begin
            model_q <= model_sel;
            key_q   <= key;
            wv_q    <= 1'b0;
         end
         if (issue) begin
            wr_addr_q  <= rom_addr_q;
            rom_addr_q <= rom_addr_q + 1'b1;
            wr_pend_q  <= 1'b1;
         end else begin
            wr_pend_q <= 1'b0;
            if (aborting) rom_addr_q <= '0;
         end
         if ((state_q == DONE) && sum_ok) wv_q <= 1'b1;
      end
   end

`ifdef WEIGHT_LOAD_CTRL_CHECKSUM_EN
   logic [N-1:0] exp_sum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum  <= '0;
         exp_sum_q <= '0;
      end else if (start_ok) begin
         checksum  <= '0;
         exp_sum_q <= expected_sum;
      end else if (ram_write_en) begin
         checksum <= checksum + ram_din;
      end
   end

   assign sum_ok = (checksum == exp_sum_q);
`else
   assign sum_ok = 1'b1;
`endif

   weight_decrypt #(
      .N  (N),
      .AW (AW)
   ) u_decrypt (
      .key   (key_q),
      .addr  (wr_addr_q),
      .data  (rom_data),
      .plain (ram_din)
   );

   assign active_model  = model_q;
   assign rom_addr      = rom_addr_q;
   assign ram_write_en  = wr_pend_q && !abort;
   assign rd_gnt        = rd_req && in_idle && !start;
   assign ram_addr      = wr_pend_q ? wr_addr_q : (rd_gnt ? rd_addr : '0);
   assign rd_valid      = rd_valid_q;
   assign rd_data       = ram_dout;
   assign busy          = !in_idle;
   assign done          = (state_q == DONE);
   assign err           = err_q || ((state_q == DONE) && !sum_ok);
   assign weights_valid = wv_q || ((state_q == DONE) && sum_ok);

endmodule
